switch_input_port: RTL and testbench
====================================

# switch_input_port

Memory-mapped input peripheral for the MIPS_R2000 board build. It is the CPU-side reader for the 16 board switches, complementing the LED/seven-segment output path. Raw `sw_i` is synchronised into CLK_CPU and debounced per bit. The CPU sees the debounced value, sticky change flags and an interrupt request through a 4-word register window.

## Interface
Parameters:
- `WIDTH`, 16: number of switch inputs, 1..32.
- `SAMPLE_DIV`, 1000: CLK_CPU cycles between debounce samples, ≥2.
- `STABLE_CNT`, 4: consecutive differing samples required to accept a new level, ≥2.

Ports:
- `CLK_CPU` in 1: CPU clock.
- `RST_CPU` in 1: reset.
- `sw_i` in WIDTH: raw asynchronous switch levels.
- `sel` in 1: register window selected this cycle.
- `we` in 1: 1 = write, 0 = read, qualified by `sel`.
- `addr` in 2: word offset.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `rvalid` out 1: single-cycle pulse, `rdata` valid.
- `irq` out 1: level interrupt request.

Reset RST_CPU, asynchronous, active-high; clock CLK_CPU.

## Operation
- **Synchroniser:** two flops per bit, reset 0. The second stage is `sync`.
- **Sample counter:** counts 0..SAMPLE_DIV-1 and wraps to 0. `tick` is asserted in the cycle where count == SAMPLE_DIV-1. Reset 0.
- **Per-bit debounce:** state is `stable` (reset 0) and `cnt` (width $clog2(STABLE_CNT), reset 0). Only a `tick` changes this state:
  - `sync == stable`: `cnt` ← 0.
  - `sync != stable` and `cnt < STABLE_CNT-1`: `cnt` ← `cnt`+1.
  - `sync != stable` and `cnt == STABLE_CNT-1`: `stable` toggles, `cnt` ← 0, and the bit's change event fires.
- **Registers (word offset):**
  - 0 DATA, RO: `stable`, zero-extended to 32 bits.
  - 1 CHANGED, W1C: a sticky bit is set by its change event. Writing 1 clears it; writing 0 has no effect.
  - 2 IRQ_EN, RW: WIDTH bits, reset 0. Upper bits read as 0.
  - 3 ID, RO: constant 32'h5357_4954.
- **Simultaneous events:** if a W1C write and a change event hit the same bit in the same cycle, the set wins. Writes to DATA and ID are ignored.
- **Reads:** `sel & ~we` in cycle N gives `rdata` and `rvalid`=1 in cycle N+1. `rdata` holds its value until the next read; `rvalid` is 0 otherwise. Reading CHANGED does not clear it.
- **irq:** registered `|(CHANGED & IRQ_EN[WIDTH-1:0])`.
- **Switches high at reset release:** these are accepted as normal changes and set their CHANGED bits. This is intended.
- **Reset mid-operation:** all flops clear immediately, including any partial debounce count. `rvalid` and `irq` drop asynchronously.
- **Reset values:** `rdata`=0, `rvalid`=0, `irq`=0.

## Timing
- **Input to `sync`:** 2 cycles.
- **`sync` to DATA:** DATA updates on the STABLE_CNT-th consecutive `tick` that sees the new level. Worst case is STABLE_CNT×SAMPLE_DIV cycles after `sync` changes.
- **Glitch rejection:** a pulse seen on fewer than STABLE_CNT consecutive ticks never reaches DATA.
- **CHANGED:** set in the same cycle DATA updates.
- **irq latency:** `irq` rises 1 cycle after CHANGED or IRQ_EN makes the AND term nonzero. It falls 1 cycle after a W1C write or IRQ_EN write clears the term.
- **Bus:** read latency 1. Writes take effect on the clock edge of the `sel & we` cycle. Back-to-back accesses are allowed every cycle.

## Structure
- **Shared package `switch_port_pkg`:** address offsets ADDR_DATA=0, ADDR_CHANGED=1, ADDR_IRQ_EN=2, ADDR_ID=3, and the SWITCH_PORT_ID constant.
- **Sub-module `sw_debounce_bit`:** one instance per bit. It contains the synchroniser, `stable`, `cnt` and the change-event output, and shares the top-level `tick`.
- **Top level:** holds the sample counter, register file, read mux and irq flop.

## Test plan
Use SAMPLE_DIV=4 and STABLE_CNT=3 in the bench.
1. **Reset, `sw_i`=0:** read addr 3 → 32'h53574954 with `rvalid` pulse 1 cycle later. Read addr 0 → 0. `irq`=0.
2. **Hold `sw_i`=16'h0001:** DATA → 1 within 2+12 cycles. CHANGED → 1, `irq` stays 0. Write IRQ_EN=1 → `irq`=1 on the following cycle.
3. **Glitch:** bit 3 high for 6 cycles (2 ticks) then low → DATA and CHANGED remain 0 throughout.
4. **W1C:** write CHANGED=1 → reads 0 and `irq` falls 1 cycle later. Repeat with the W1C aligned to a new bit-0 change event → CHANGED bit 0 stays 1.
5. **Reset mid-debounce:** assert RST_CPU after 2 differing ticks → DATA, CHANGED, IRQ_EN, `irq` and `rvalid` all 0 immediately. The debounce restarts from `cnt`=0.
6. **Bus rules:** write 32'hFFFF to DATA → DATA unchanged. A read yields exactly one `rvalid` cycle. Back-to-back reads of addr 0 then 3 return the correct data on consecutive cycles.

Source files
------------

// File: rtl/switch_port_pkg.sv
// switch_port_pkg: register map shared by the switch input port.
package switch_port_pkg;
   typedef enum logic [1:0] {
      ADDR_DATA    = 2'd0,
      ADDR_CHANGED = 2'd1,
      ADDR_IRQ_EN  = 2'd2,
      ADDR_ID      = 2'd3
   } addr_e;
   localparam logic [31:0] SWITCH_PORT_ID = 32'h5357_4954;
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop synchroniser plus tick-sampled debounce for one switch.
module sw_debounce_bit #(
   parameter int STABLE_CNT = 4
) (
   input  logic CLK_CPU,
   input  logic RST_CPU,
   input  logic i_sw,
   input  logic i_tick,
   output logic o_stable,
   output logic o_change
);
   localparam int CW = $clog2(STABLE_CNT);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);
   logic          r_meta;
   logic          r_sync;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   assign w_diff   = r_sync ^ o_stable;
   assign o_change = i_tick & w_diff & (r_cnt == LAST);
   always_ff @(posedge CLK_CPU or posedge RST_CPU)
      if (RST_CPU) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         o_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_meta <= i_sw;
         r_sync <= r_meta;
         if (i_tick) begin
            r_cnt <= (w_diff && r_cnt != LAST) ? r_cnt + CW'(1) : '0;
            if (o_change) o_stable <= ~o_stable;
         end
      end
endmodule

// File: rtl/switch_input_port.sv
// switch_input_port: debounced switch reader with sticky change flags and irq
// behind a 4-word register window.
module switch_input_port
   import switch_port_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SAMPLE_DIV = 1000,
   parameter int STABLE_CNT = 4
) (
   input  logic             CLK_CPU,
   input  logic             RST_CPU,
   input  logic [WIDTH-1:0] sw_i,
   input  logic             sel,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rvalid,
   output logic             irq
);
   localparam int DW = $clog2(SAMPLE_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
   logic [DW-1:0]    r_div;
   logic [WIDTH-1:0] r_changed;
   logic [WIDTH-1:0] r_irq_en;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_event;
   logic [WIDTH-1:0] w_clr;
   logic [31:0]      w_rmux;
   logic             w_tick;
   logic             w_wr;
   logic             w_unused_wdata;
   assign w_unused_wdata = ^wdata;
   assign w_tick = r_div == DIV_LAST;
   assign w_wr   = sel & we;
   assign w_clr  = (w_wr && addr == ADDR_CHANGED) ? wdata[WIDTH-1:0] : '0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(.STABLE_CNT(STABLE_CNT)) u_bit (
         .CLK_CPU  (CLK_CPU),
         .RST_CPU  (RST_CPU),
         .i_sw     (sw_i[i]),
         .i_tick   (w_tick),
         .o_stable (w_stable[i]),
         .o_change (w_event[i])
      );
   end
   always_comb
      w_rmux = (addr == ADDR_DATA)    ? 32'(w_stable)  :
               (addr == ADDR_CHANGED) ? 32'(r_changed) :
               (addr == ADDR_IRQ_EN)  ? 32'(r_irq_en)  : SWITCH_PORT_ID;
   // A change event overrides a same-cycle W1C on its bit.
   always_ff @(posedge CLK_CPU or posedge RST_CPU)
      if (RST_CPU) begin
         r_div     <= '0;
         r_changed <= '0;
         r_irq_en  <= '0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         irq       <= 1'b0;
      end else begin
         r_div     <= w_tick ? '0 : r_div + DW'(1);
         r_changed <= (r_changed & ~w_clr) | w_event;
         if (w_wr && addr == ADDR_IRQ_EN) r_irq_en <= wdata[WIDTH-1:0];
         if (sel && !we) rdata <= w_rmux;
         rvalid    <= sel & ~we;
         irq       <= |(r_changed & r_irq_en);
      end
endmodule

// File: tb/tb_switch_input_port.sv
// tb_switch_input_port: directed stimulus with a read scoreboard for switch_input_port.
module tb_switch_input_port;
   import switch_port_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] sw;
   logic        sel, we;
   logic [1:0]  addr;
   logic [31:0] wdata, rdata;
   logic        rvalid, irq;
   int          e;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   switch_input_port #(.WIDTH(16), .SAMPLE_DIV(4), .STABLE_CNT(3)) dut (
      .CLK_CPU (clk),
      .RST_CPU (rst),
      .sw_i    (sw),
      .sel     (sel),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // e tracks the sample divider phase: a tick cycle has e % 4 == 3.
   always @(posedge clk or posedge rst)
      if (rst) e <= 0;
      else e <= e + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   always @(negedge clk)
      if (!rst && rvalid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h, expected no read pending", rdata);
         end else chk(name_q.pop_front(), rdata, exp_q.pop_front());
      end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] x, input string nm);
      sel = 1'b1; we = 1'b0; addr = a;
      exp_q.push_back(x);
      name_q.push_back(nm);
      cyc(1);
      sel = 1'b0;
      chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      cyc(1);
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic align_tick();
      while (e % 4 != 3) cyc(1);
   endtask

   initial begin
      sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0;
      cyc(2);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_rvalid", 32'(rvalid), 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      // 1: identity and idle data
      rd(ADDR_ID, SWITCH_PORT_ID, "id");
      rd(ADDR_DATA, 32'd0, "data_idle");
      chk("idle_irq", 32'(irq), 32'd0);
      // 2: hold bit 0 high
      sw = 16'h0001;
      cyc(14);
      rd(ADDR_DATA, 32'd1, "data_bit0");
      rd(ADDR_CHANGED, 32'd1, "changed_bit0");
      chk("irq_masked", 32'(irq), 32'd0);
      wr(ADDR_IRQ_EN, 32'd1);
      chk("irq_en_edge", 32'(irq), 32'd0);
      cyc(1);
      chk("irq_en_rise", 32'(irq), 32'd1);
      // 3: glitch on bit 3 spanning at most two ticks
      sw = 16'h0009;
      cyc(3);
      rd(ADDR_DATA, 32'd1, "glitch_mid");
      cyc(2);
      sw = 16'h0001;
      cyc(20);
      rd(ADDR_DATA, 32'd1, "glitch_data");
      rd(ADDR_CHANGED, 32'd1, "glitch_changed");
      // 4: W1C, then W1C colliding with a bit-0 change event
      wr(ADDR_CHANGED, 32'd1);
      chk("w1c_irq_hold", 32'(irq), 32'd1);
      cyc(1);
      chk("w1c_irq_fall", 32'(irq), 32'd0);
      rd(ADDR_CHANGED, 32'd0, "w1c_cleared");
      align_tick();
      sw = 16'h0000;
      cyc(12);
      wr(ADDR_CHANGED, 32'd1);
      rd(ADDR_CHANGED, 32'd1, "w1c_set_wins");
      rd(ADDR_DATA, 32'd0, "data_fall");
      chk("irq_refire", 32'(irq), 32'd1);
      // 5: reset after two differing ticks on bit 1
      align_tick();
      sw = 16'h0002;
      cyc(8);
      sel = 1'b1; we = 1'b0; addr = ADDR_ID;
      cyc(1);
      sel = 1'b0;
      chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
      chk("pre_rst_irq", 32'(irq), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      cyc(2);
      rst = 1'b0;
      rd(ADDR_DATA, 32'd0, "rst_data");
      rd(ADDR_CHANGED, 32'd0, "rst_changed");
      rd(ADDR_IRQ_EN, 32'd0, "rst_irq_en");
      while (e != 11) cyc(1);
      rd(ADDR_DATA, 32'd0, "restart_data_pre");
      rd(ADDR_DATA, 32'd2, "restart_data");
      rd(ADDR_CHANGED, 32'd2, "restart_changed");
      chk("restart_irq", 32'(irq), 32'd0);
      // 6: bus rules
      wr(ADDR_DATA, 32'h0000_FFFF);
      rd(ADDR_DATA, 32'd2, "data_ro");
      wr(ADDR_ID, 32'd0);
      rd(ADDR_ID, SWITCH_PORT_ID, "id_ro");
      wr(ADDR_CHANGED, 32'd0);
      rd(ADDR_CHANGED, 32'd2, "w0_no_effect");
      rd(ADDR_IRQ_EN, 32'd0, "single_read");
      cyc(1);
      chk("rvalid_single", 32'(rvalid), 32'd0);
      rd(ADDR_DATA, 32'd2, "b2b_data");
      rd(ADDR_ID, SWITCH_PORT_ID, "b2b_id");
      cyc(1);
      wr(ADDR_IRQ_EN, 32'hFFFF_FFFF);
      chk("irq_en2_edge", 32'(irq), 32'd0);
      cyc(1);
      chk("irq_en2_rise", 32'(irq), 32'd1);
      rd(ADDR_IRQ_EN, 32'h0000_FFFF, "irq_en_width");
      wr(ADDR_IRQ_EN, 32'd0);
      chk("irq_dis_hold", 32'(irq), 32'd1);
      cyc(1);
      chk("irq_dis_fall", 32'(irq), 32'd0);
      cyc(3);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
